// File: rtl/excutor_pkg.sv
// Shared definitions for the excutor command engine: op codes, FSM states and OpCode field positions.
// OP_SUB is only executed when EXCUTOR_SUB_EN is defined; otherwise it decodes as an undefined op.
package excutor_pkg;

    localparam int OPCODE_W = 20;
    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 16;
    localparam int A_MSB    = 15;
    localparam int A_LSB    = 8;
    localparam int B_MSB    = 7;
    localparam int B_LSB    = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SET  = 4'h1;
    localparam logic [3:0] OP_COPY = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_READ  = S_READ,
        ST_WRITE = S_WRITE,
        ST_DONE  = S_DONE,
        ST_HOLD  = S_HOLD
    } state_t;

    function automatic logic [3:0] op_field(input logic [OPCODE_W-1:0] opcode);
        return opcode[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/excutor_if.sv
// Command channel of the excutor: the issuer drives OpCode, the engine answers with a one-cycle Done pulse.
interface excutor_if;
    import excutor_pkg::*;

    logic [OPCODE_W-1:0] OpCode;
    logic                Done;

    modport master (output OpCode, input Done);
    modport slave  (input OpCode, output Done);
endinterface

// File: rtl/excutor_memory.sv
// Companion word memory for the excutor: synchronous write, combinational read onto the shared bus.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  RW,
    input  logic [ADDR_WIDTH-1:0] Select,
    inout  wire  [DATA_WIDTH-1:0] DataBus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_word [DEPTH];

    // Clear on reset, otherwise store the bus value on write cycles
    always_ff @(posedge Clock) begin
        if (ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
            end
        end else if (RW) begin
            r_word[Select] <= DataBus;
        end
    end

    assign DataBus = RW ? {DATA_WIDTH{1'bz}} : r_word[Select];

endmodule

// File: rtl/excutor.sv
// Executes SET / COPY / ADD commands against an external memory over a shared tri-state bus.
// Define EXCUTOR_SUB_EN to enable op 0100 (SUB); without it that op finishes as undefined.
module excutor
    import excutor_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    excutor_if.slave              cmd,
    output logic [ADDR_WIDTH-1:0] MemorySelect,
    output logic                  MemoryRW,
    inout  wire  [DATA_WIDTH-1:0] MemoryData
);

    state_t                r_state, w_state_nx;
    logic [3:0]            r_op, w_op_nx;
    logic [ADDR_WIDTH-1:0] r_a, w_a_nx;
    logic [7:0]            r_b, w_b_nx;
    logic [DATA_WIDTH-1:0] r_temp, w_temp_nx;
    logic [ADDR_WIDTH-1:0] r_sel, w_sel_nx;
    logic                  r_rw, w_rw_nx;
    logic                  r_done, w_done_nx;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic [3:0]            w_in_op;
    logic [ADDR_WIDTH-1:0] w_in_a;
    logic [7:0]            w_in_b;
    logic                  w_unused;

    assign w_in_op  = op_field(cmd.OpCode);
    assign w_in_a   = cmd.OpCode[A_LSB +: ADDR_WIDTH];
    assign w_in_b   = cmd.OpCode[B_MSB:B_LSB];
    assign w_unused = ^cmd.OpCode[A_MSB:A_LSB+ADDR_WIDTH];

    // Next-state and next-output decode; bus controls are registered so they change only on state entry
    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_temp_nx  = r_temp;
        w_sel_nx   = {ADDR_WIDTH{1'b0}};
        w_rw_nx    = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_op != OP_NOP) begin
                    w_op_nx = w_in_op;
                    w_a_nx  = w_in_a;
                    w_b_nx  = w_in_b;
                    case (w_in_op)
                        OP_SET: begin
                            w_state_nx = ST_WRITE;
                            w_rw_nx    = 1'b1;
                            w_sel_nx   = w_in_a;
                        end
                        OP_COPY: begin
                            w_state_nx = ST_READ;
                            w_sel_nx   = w_in_b[ADDR_WIDTH-1:0];
                        end
                        OP_ADD: begin
                            w_state_nx = ST_READ;
                            w_sel_nx   = w_in_a;
                        end
`ifdef EXCUTOR_SUB_EN
                        OP_SUB: begin
                            w_state_nx = ST_READ;
                            w_sel_nx   = w_in_a;
                        end
`endif
                        default: begin
                            w_state_nx = ST_DONE;
                            w_done_nx  = 1'b1;
                        end
                    endcase
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_READ: begin
                w_temp_nx  = MemoryData;
                w_state_nx = ST_WRITE;
                w_rw_nx    = 1'b1;
                w_sel_nx   = r_a;
            end
            ST_WRITE: begin
                w_state_nx = ST_DONE;
                w_done_nx  = 1'b1;
            end
            ST_DONE: begin
                w_state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for op 0 so a held command is never executed twice
                if (w_in_op == OP_NOP) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_HOLD;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Write data from the latched command and the value captured in READ
    always_comb begin
        case (r_op)
            OP_SET:  w_wdata = DATA_WIDTH'(r_b);
            OP_ADD:  w_wdata = r_temp + DATA_WIDTH'(r_b);
`ifdef EXCUTOR_SUB_EN
            OP_SUB:  w_wdata = r_temp - DATA_WIDTH'(r_b);
`endif
            default: w_wdata = r_temp;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (ResetN) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_a     <= {ADDR_WIDTH{1'b0}};
            r_b     <= 8'h00;
            r_temp  <= {DATA_WIDTH{1'b0}};
            r_sel   <= {ADDR_WIDTH{1'b0}};
            r_rw    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_temp  <= w_temp_nx;
            r_sel   <= w_sel_nx;
            r_rw    <= w_rw_nx;
            r_done  <= w_done_nx;
        end
    end

    assign MemorySelect = r_sel;
    assign MemoryRW     = r_rw;
    assign cmd.Done     = r_done;
    assign MemoryData   = r_rw ? w_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_excutor.sv
// Self-checking bench for excutor + memory: directed scenarios plus randomized commands against a word-array model.
module tb_excutor;
    import excutor_pkg::*;

    logic       Clock = 1'b0;
    logic       ResetN;
    wire  [7:0] mem_data;
    logic [1:0] mem_sel;
    logic       mem_rw;

    int n_checks = 0;
    int n_pass   = 0;
    int n_dones  = 0;
    logic [7:0] model_mem [4];

    excutor_if u_cmd();

    excutor #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .cmd          (u_cmd),
        .MemorySelect (mem_sel),
        .MemoryRW     (mem_rw),
        .MemoryData   (mem_data)
    );

    memory #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_mem (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .RW      (mem_rw),
        .Select  (mem_sel),
        .DataBus (mem_data)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit sub_enabled();
`ifdef EXCUTOR_SUB_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycle (counting acceptance as 1) in which Done is expected
    function automatic int exp_latency(input logic [3:0] op);
        if (op == 4'h1) return 3;
        if (op == 4'h2 || op == 4'h3) return 4;
        if (op == 4'h4 && sub_enabled()) return 4;
        return 2;
    endfunction

    function automatic bit writes_mem(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h3) || (op == 4'h4 && sub_enabled());
    endfunction

    function automatic logic [7:0] model_result(input logic [19:0] opc);
        logic [7:0] a_val;
        logic [7:0] imm;
        a_val = model_mem[opc[9:8]];
        imm   = opc[7:0];
        case (opc[19:16])
            4'h1:    return imm;
            4'h2:    return model_mem[opc[1:0]];
            4'h3:    return 8'((int'(a_val) + int'(imm)) % 256);
            4'h4:    return 8'((int'(a_val) - int'(imm) + 256) % 256);
            default: return a_val;
        endcase
    endfunction

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_mem%0d", tag, i), 32'(u_mem.r_word[i]), 32'(model_mem[i]));
        end
    endtask

    // Issue one command from IDLE, hold it 12 cycles, then release to op 0
    task automatic run_op(input string tag, input logic [19:0] opc, input bit scramble);
        int lat;
        int dones;
        int writes;
        logic [1:0] wsel;
        logic [7:0] wdat;
        logic [7:0] exp_dat;
        logic [3:0] op;
        op = opc[19:16];
        lat = 0; dones = 0; writes = 0; wsel = 2'd0; wdat = 8'd0;
        exp_dat = model_result(opc);
        u_cmd.OpCode = opc;
        for (int c = 1; c <= 12; c++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (scramble && c == 1) begin
                u_cmd.OpCode = {4'(1 + $urandom_range(0, 4)), 16'($urandom)};
            end
            if (u_cmd.Done) begin
                dones++;
                if (lat == 0) lat = c + 1;
            end
            if (mem_rw) begin
                writes++;
                wsel = mem_sel;
                wdat = mem_data;
            end
        end
        check({tag, "_hold_rw"}, 32'(mem_rw), 32'd0);
        check({tag, "_hold_sel"}, 32'(mem_sel), 32'd0);
        check({tag, "_latency"}, 32'(lat), 32'(exp_latency(op)));
        check({tag, "_dones"}, 32'(dones), 32'd1);
        check({tag, "_writes"}, 32'(writes), writes_mem(op) ? 32'd1 : 32'd0);
        if (writes_mem(op)) begin
            check({tag, "_wr_addr"}, 32'(wsel), 32'(opc[9:8]));
            check({tag, "_wr_data"}, 32'(wdat), 32'(exp_dat));
            model_mem[opc[9:8]] = exp_dat;
        end
        n_dones += dones;
        u_cmd.OpCode = 20'h0;
        @(posedge Clock);
        @(negedge Clock);
        check_mem(tag);
    endtask

    initial begin
        int d0;
        logic [19:0] opc;
        ResetN = 1'b1;
        u_cmd.OpCode = 20'h0;
        for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b0;
        check("rst_done", 32'(u_cmd.Done), 32'd0);
        check("rst_rw", 32'(mem_rw), 32'd0);
        check("rst_sel", 32'(mem_sel), 32'd0);
        check_mem("rst");

        run_op("set_2aa", 20'h1_02_AA, 1'b0);
        check("set_2aa_direct", 32'(u_mem.r_word[2]), 32'h00AA);

        run_op("set_14a", 20'h1_01_4A, 1'b0);
        run_op("copy_12", 20'h2_01_02, 1'b0);
        check("copy_direct_m1", 32'(u_mem.r_word[1]), 32'h00AA);
        check("copy_direct_m2", 32'(u_mem.r_word[2]), 32'h00AA);

        d0 = n_dones;
        for (int k = 0; k < 4; k++) run_op($sformatf("add4_%0d", k), 20'h3_01_01, 1'b0);
        check("add4_direct", 32'(u_mem.r_word[1]), 32'h00AE);
        check("add4_dones", 32'(n_dones - d0), 32'd4);

        run_op("set_3ff", 20'h1_03_FF, 1'b0);
        run_op("add_wrap", 20'h3_03_01, 1'b0);
        check("add_wrap_direct", 32'(u_mem.r_word[3]), 32'h0000);
        run_op("set_alias", 20'h1_05_11, 1'b0);
        check("set_alias_direct", 32'(u_mem.r_word[1]), 32'h0011);

        run_op("add_held", 20'h3_01_01, 1'b0);
        check("add_held_direct", 32'(u_mem.r_word[1]), 32'h0012);

        run_op("op4", 20'h4_02_05, 1'b0);
        run_op("undef5", 20'h5_01_33, 1'b0);
        run_op("undefF", 20'hF_00_77, 1'b1);

        for (int k = 0; k < 30; k++) begin
            opc = {4'(1 + $urandom_range(0, 4)), 16'($urandom)};
            run_op($sformatf("rnd%0d", k), opc, 1'($urandom_range(0, 1)));
        end

        // Reset in the READ cycle of an ADD
        u_cmd.OpCode = 20'h3_01_01;
        @(posedge Clock);
        @(negedge Clock);
        check("rdrst_read_rw", 32'(mem_rw), 32'd0);
        check("rdrst_read_sel", 32'(mem_sel), 32'd1);
        ResetN = 1'b1;
        u_cmd.OpCode = 20'h0;
        @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b0;
        for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
        check("rdrst_done", 32'(u_cmd.Done), 32'd0);
        check("rdrst_rw", 32'(mem_rw), 32'd0);
        check("rdrst_sel", 32'(mem_sel), 32'd0);
        check_mem("rdrst");
        run_op("post_rst_set", 20'h1_00_5C, 1'b0);
        check("post_rst_direct", 32'(u_mem.r_word[0]), 32'h005C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/excutor.md
EXCUTOR -- requirements
Module: excutor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width; opcode immediate field width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2: width of MemorySelect, so the memory holds 2^ADDR_WIDTH words.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ResetN, input, 1 bit: synchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port OpCode, input, 20 bits: [19:16] op, [15:8] field A (destination address), [7:0] field B (immediate or source address).
REQ-006 SHALL have port MemorySelect, output, ADDR_WIDTH bits: memory word address.
REQ-007 SHALL have port MemoryRW, output, 1 bit: 1 = write cycle, 0 = read cycle.
REQ-008 SHALL have port MemoryData, inout, DATA_WIDTH bits: shared data bus; excutor drives it only while MemoryRW = 1, otherwise high-Z.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-010 SHALL decode ops: 0000 NOP/idle; 0001 SET mem[A] = B; 0010 COPY mem[A] = mem[B]; 0011 ADD mem[A] = mem[A] + B.
REQ-011 SHALL use only the low ADDR_WIDTH bits of A, and of B when B is an address; upper bits are ignored (A = 0x05 addresses word 1).
REQ-012 SHALL perform ADD modulo 2^DATA_WIDTH with no carry output (0xFF + 1 = 0x00).
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE, HOLD.
REQ-014 IDLE: when op != 0, SHALL latch OpCode; go to WRITE for SET, READ for COPY/ADD, DONE for any undefined op.
REQ-015 READ: SHALL drive MemoryRW = 0 with MemorySelect = B (COPY) or A (ADD), capture MemoryData into a temp register at the clock edge, then go to WRITE.
REQ-016 WRITE: SHALL drive MemoryRW = 1, MemorySelect = A, and MemoryData = B (SET), temp (COPY) or temp + B (ADD); memory writes at that edge; then go to DONE.
REQ-017 DONE: Done SHALL be 1 for exactly this cycle; then go to HOLD.
REQ-018 HOLD: SHALL stay until OpCode[19:16] == 0, then go to IDLE; an opcode is never re-executed without passing through op 0.
REQ-019 Latency from acceptance in IDLE: SET gives Done in the 3rd cycle; COPY and ADD in the 4th; undefined ops in the 2nd, with no memory write.
REQ-020 OpCode changes after acceptance SHALL NOT affect the running operation; the latched copy is used.
REQ-021 Outside READ/WRITE, SHALL drive MemoryRW = 0 and MemorySelect = 0.
REQ-022 Companion memory: on a rising edge with RW = 1, SHALL write DataBus into word[Select]; while RW = 0, SHALL drive DataBus combinationally with word[Select]; synchronous reset clears all words to 0.

Reset
REQ-023 ResetN = 1 at a rising edge SHALL force IDLE, Done = 0, MemoryRW = 0, MemorySelect = 0, temp = 0 and the bus to high-Z, including mid-operation; the interrupted write does not occur unless it was already in WRITE at that edge.

Configuration
REQ-024 With EXCUTOR_SUB_EN defined, op 0100 SHALL be SUB: mem[A] = mem[A] - B modulo 2^DATA_WIDTH, with the same timing as ADD.
REQ-025 Without EXCUTOR_SUB_EN, op 0100 SHALL be handled as an undefined op: Done after 1 cycle, no memory access.

Structure
REQ-026 A shared package SHALL hold the op-code constants (OP_NOP, OP_SET, OP_COPY, OP_ADD, OP_SUB), the FSM state enum and the opcode field bit positions.
REQ-027 The memory SHALL be a separate module, memory (parameters DATA_WIDTH, ADDR_WIDTH), instantiated beside excutor in the enclosing design; excutor contains no sub-module.

Verification
REQ-028 Reset, then SET 0x1_02_AA -> Done pulses once; mem[2] = 0xAA.
REQ-029 SET 0x1_01_4A -> mem[1] = 0x4A; then COPY 0x2_01_02 -> mem[1] = 0xAA, mem[2] unchanged.
REQ-030 ADD 0x3_01_01 issued four times, returning to op 0 between issues -> mem[1] = 0xAE; Done pulses exactly four times.
REQ-031 SET mem[3] = 0xFF, then ADD 0x3_03_01 -> mem[3] = 0x00; SET 0x1_05_11 -> mem[1] = 0x11.
REQ-032 Hold ADD 0x3_01_01 asserted for 10 cycles -> exactly one increment and one Done.
REQ-033 Assert ResetN during the READ state of an ADD -> no write occurs, all memory words = 0, outputs at reset values; a later SET works normally.
